instr_memory: RTL

Instruction-side responder for `mips_cpu_harvard`, the other end of the CPU's instruction fetch port. A program image is streamed in over a valid/ready load port while the CPU is held in reset. The image is then served combinationally on `instr_readdata` for any `instr_address` in the boot region starting at 0xBFC00000. The block flags termination when the CPU fetches address 0, so benches and the top level can end runs without hard-coding instruction decode.

---
 rtl/instr_memory_if.sv | 20 ++
 rtl/instr_memory.sv | 102 ++++++++++
 2 files changed

// File: rtl/instr_memory_if.sv
// Instruction fetch and image-load bus between a CPU/loader (master)
// and the instruction memory (slave).
interface instr_memory_if;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;

  modport master (
    output instr_address, load_valid, load_data, load_last,
    input  instr_readdata, load_ready
  );

  modport slave (
    input  instr_address, load_valid, load_data, load_last,
    output instr_readdata, load_ready
  );
endinterface

// File: rtl/instr_memory.sv
// Boot-region instruction memory: streams in a program image while holding the
// CPU in reset, then serves fetches combinationally and flags a fetch of address 0.
module instr_memory #(
  parameter int unsigned DEPTH = 64,
  parameter logic [31:0] BASE  = 32'hBFC00000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clk_enable,
  instr_memory_if.slave  bus,
  output logic           cpu_reset,
  output logic           halted,
  output logic           load_error,
  output logic [15:0]    fetch_count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [31:0]   mem_q [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   len_q, len_d;
  logic          halted_q, halted_d;
  logic          err_q, err_d;
  logic [15:0]   count_q, count_d;

  logic [31:0]   offset;
  logic          inRange;
  logic          transfer;

  // Only words that were actually loaded, on word boundaries, are visible.
  assign offset   = bus.instr_address - BASE;
  assign inRange  = (offset[1:0] == 2'b00) && (offset[31:2] < 30'(len_q));

  assign bus.instr_readdata = (inRange && (state_q != ST_LOAD)) ? mem_q[offset[AW+1:2]] : 32'd0;
  assign bus.load_ready     = (state_q == ST_LOAD) && clk_enable;
  assign transfer           = bus.load_valid && bus.load_ready;

  assign cpu_reset   = reset || (state_q == ST_LOAD);
  assign halted      = halted_q;
  assign load_error  = err_q;
  assign fetch_count = count_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    halted_d = halted_q;
    err_d    = err_q;
    count_d  = count_q;
    if (clk_enable) begin
      case (state_q)
        ST_LOAD: begin
          if (transfer) begin
            ptr_d = ptr_q + AW'(1);
            len_d = (AW+1)'(ptr_q) + (AW+1)'(1);
            if (bus.load_last || (ptr_q == LAST_IDX)) state_d = ST_RUN;
            if ((ptr_q == LAST_IDX) && !bus.load_last) err_d = 1'b1;
          end
        end
        ST_RUN: begin
          // The terminating fetch of address 0 is not counted as a run cycle.
          if (bus.instr_address == 32'd0) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      ptr_q    <= '0;
      len_q    <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; a reset only hides it by zeroing len_q.
  always_ff @(posedge clk) begin
    if (!reset && transfer) mem_q[ptr_q] <= bus.load_data;
  end
endmodule
